// File: rtl/atm_credential_entry.sv
// Keypad front end for the ATM controller: assembles a 12-bit account number
// and a 4-bit PIN from decimal key presses, strobes them to the authentication
// lookup, tracks failed attempts with a timed lockout, and abandons a stalled
// entry after an inactivity timeout.
module atm_credential_entry #(
  parameter int MAX_TRIES    = 3,
  parameter int LOCK_CYCLES  = 200,
  parameter int IDLE_TIMEOUT = 100,
  parameter int AUTH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        auth_done,
  input  logic        auth_ok,
  input  logic        logout,
  output logic [11:0] acc_number,
  output logic [3:0]  pin,
  output logic        cred_valid,
  output logic        session_active,
  output logic        locked,
  output logic        entry_error,
  output logic [2:0]  digit_count,
  output logic [1:0]  tries_left
);

  // One shared timer serves idle, auth and lockout: the three never overlap.
  localparam int TMAX_A = (LOCK_CYCLES > IDLE_TIMEOUT) ? LOCK_CYCLES : IDLE_TIMEOUT;
  localparam int TMAX   = (TMAX_A > AUTH_TIMEOUT) ? TMAX_A : AUTH_TIMEOUT;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] AUTH_LAST = TW'(AUTH_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    TRIES_INIT = 2'(MAX_TRIES);

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  typedef enum logic [2:0] {
    S_ENTER_ACC,
    S_ENTER_PIN,
    S_WAIT_AUTH,
    S_SESSION,
    S_LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [11:0]   acc_q, acc_d;
  logic [3:0]    pin_q, pin_d;
  logic [2:0]    dc_q, dc_d;
  logic [1:0]    tries_q, tries_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cred_q, cred_d;
  logic          err_q, err_d;
  logic          session_q, locked_q;
  logic          clear_all;
  logic          auth_fail;

  logic        is_digit;
  logic [13:0] acc_calc;
  logic [6:0]  pin_calc;

  // Candidate field values if the current key is appended as a digit; the
  // digit-count limits keep both well inside their widths.
  assign is_digit = (key_code <= 4'd9);
  assign acc_calc = 14'(acc_q) * 14'd10 + 14'(key_code);
  assign pin_calc = 7'(pin_q) * 7'd10 + 7'(key_code);

  // Next-state logic: key handling, timers, auth outcome and retry accounting.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which is what would otherwise infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    pin_d     = pin_q;
    dc_d      = dc_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    cred_d    = 1'b0;
    err_d     = 1'b0;
    clear_all = 1'b0;
    auth_fail = 1'b0;

    unique case (state_q)
      S_ENTER_ACC, S_ENTER_PIN: begin
        if (key_valid) begin
          // Any key, even an ignored one, counts as activity.
          timer_d = '0;
          if (is_digit) begin
            if (state_q == S_ENTER_ACC && dc_q < 3'd4) begin
              if (acc_calc > 14'd4095) begin
                acc_d = '0;
                dc_d  = '0;
                err_d = 1'b1;
              end else begin
                acc_d = acc_calc[11:0];
                dc_d  = dc_q + 3'd1;
              end
            end else if (state_q == S_ENTER_PIN && dc_q < 3'd2) begin
              if (pin_calc > 7'd15) begin
                pin_d = '0;
                dc_d  = '0;
                err_d = 1'b1;
              end else begin
                pin_d = pin_calc[3:0];
                dc_d  = dc_q + 3'd1;
              end
            end
          end else if (key_code == KEY_CLEAR) begin
            if (state_q == S_ENTER_ACC) acc_d = '0;
            else                        pin_d = '0;
            dc_d = '0;
          end else if (key_code == KEY_ENTER && dc_q != 3'd0) begin
            dc_d = '0;
            if (state_q == S_ENTER_ACC) begin
              state_d = S_ENTER_PIN;
            end else begin
              state_d = S_WAIT_AUTH;
              cred_d  = 1'b1;
            end
          end else if (key_code == KEY_CANCEL) begin
            clear_all = 1'b1;
            state_d   = S_ENTER_ACC;
          end
        end else if (state_q == S_ENTER_PIN || dc_q != 3'd0) begin
          // The idle timer only runs once entry is under way, so a resting
          // keypad does not raise an error every timeout period.
          if (timer_q == IDLE_LAST) begin
            clear_all = 1'b1;
            err_d     = 1'b1;
            timer_d   = '0;
            state_d   = S_ENTER_ACC;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      S_WAIT_AUTH: begin
        // auth_done takes priority over a timeout landing in the same cycle.
        if (auth_done) begin
          if (auth_ok) begin
            state_d = S_SESSION;
            tries_d = TRIES_INIT;
          end else begin
            auth_fail = 1'b1;
          end
        end else if (timer_q == AUTH_LAST) begin
          auth_fail = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        if (auth_fail) begin
          err_d     = 1'b1;
          tries_d   = tries_q - 2'd1;
          clear_all = 1'b1;
          state_d   = (tries_q <= 2'd1) ? S_LOCKED : S_ENTER_ACC;
        end
      end

      S_SESSION: begin
        if (logout) begin
          clear_all = 1'b1;
          state_d   = S_ENTER_ACC;
        end
      end

      S_LOCKED: begin
        if (timer_q == LOCK_LAST) begin
          tries_d = TRIES_INIT;
          state_d = S_ENTER_ACC;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = S_ENTER_ACC;
    endcase

    if (clear_all) begin
      acc_d = '0;
      pin_d = '0;
      dc_d  = '0;
    end
    // Every state starts its own timing window from zero.
    if (state_d != state_q) timer_d = '0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_ENTER_ACC;
      acc_q     <= '0;
      pin_q     <= '0;
      dc_q      <= '0;
      tries_q   <= TRIES_INIT;
      timer_q   <= '0;
      cred_q    <= 1'b0;
      err_q     <= 1'b0;
      session_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      pin_q     <= pin_d;
      dc_q      <= dc_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      cred_q    <= cred_d;
      err_q     <= err_d;
      session_q <= (state_d == S_SESSION);
      locked_q  <= (state_d == S_LOCKED);
    end
  end

  assign acc_number     = acc_q;
  assign pin            = pin_q;
  assign cred_valid     = cred_q;
  assign session_active = session_q;
  assign locked         = locked_q;
  assign entry_error    = err_q;
  assign digit_count    = dc_q;
  assign tries_left     = tries_q;

endmodule

// File: tb/tb_atm_credential_entry.sv
// Directed bench for atm_credential_entry: inputs change on the falling edge,
// outputs are compared on the falling edge after the capturing rising edge.
module tb_atm_credential_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        auth_done;
  logic        auth_ok;
  logic        logout;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic        cred_valid;
  logic        session_active;
  logic        locked;
  logic        entry_error;
  logic [2:0]  digit_count;
  logic [1:0]  tries_left;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_ENT = 4'hB;
  localparam logic [3:0] K_CAN = 4'hC;

  always #5 clk = ~clk;

  atm_credential_entry dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .auth_done      (auth_done),
    .auth_ok        (auth_ok),
    .logout         (logout),
    .acc_number     (acc_number),
    .pin            (pin),
    .cred_valid     (cred_valid),
    .session_active (session_active),
    .locked         (locked),
    .entry_error    (entry_error),
    .digit_count    (digit_count),
    .tries_left     (tries_left)
  );

  // One key strobe, captured by exactly one rising edge.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic auth(input logic ok);
    @(negedge clk);
    auth_done = 1'b1;
    auth_ok   = ok;
    @(negedge clk);
    auth_done = 1'b0;
    auth_ok   = 1'b0;
  endtask

  task automatic attempt(input logic [3:0] a, input logic [3:0] p, input logic ok);
    press(a);
    press(K_ENT);
    press(p);
    press(K_ENT);
    auth(ok);
  endtask

  task automatic test_reset;
    logic [24:0] got;
    got = {acc_number, pin, cred_valid, session_active, locked, entry_error, digit_count, tries_left};
    vectors++; if (got !== {12'd0, 4'd0, 4'b0000, 3'd0, 2'd3}) begin miscompares++; $display("FAIL reset_state: got %h want %h", got, {12'd0, 4'd0, 4'b0000, 3'd0, 2'd3}); end
  endtask

  task automatic test_login;
    press(4); press(0); press(2); press(3);
    vectors++; if (acc_number !== 12'd4023 || digit_count !== 3'd4) begin miscompares++; $display("FAIL login_acc: got %0d/%0d want 4023/4", acc_number, digit_count); end
    press(K_ENT);
    vectors++; if (digit_count !== 3'd0) begin miscompares++; $display("FAIL login_field_change: got dc %0d want 0", digit_count); end
    press(3); press(K_ENT);
    vectors++; if (cred_valid !== 1'b1 || acc_number !== 12'd4023 || pin !== 4'd3) begin miscompares++; $display("FAIL login_cred: got cv %b acc %0d pin %0d want 1/4023/3", cred_valid, acc_number, pin); end
    @(negedge clk);
    vectors++; if (cred_valid !== 1'b0) begin miscompares++; $display("FAIL login_cred_pulse: got %b want 0", cred_valid); end
    auth_done = 1'b1; auth_ok = 1'b1;
    @(negedge clk);
    auth_done = 1'b0; auth_ok = 1'b0;
    vectors++; if (session_active !== 1'b1 || tries_left !== 2'd3 || acc_number !== 12'd4023) begin miscompares++; $display("FAIL login_session: got sa %b tries %0d acc %0d want 1/3/4023", session_active, tries_left, acc_number); end
    press(7);
    vectors++; if (pin !== 4'd3 || digit_count !== 3'd0) begin miscompares++; $display("FAIL session_keys_ignored: got pin %0d dc %0d want 3/0", pin, digit_count); end
    @(negedge clk); logout = 1'b1;
    @(negedge clk); logout = 1'b0;
    vectors++; if (session_active !== 1'b0 || acc_number !== 12'd0 || pin !== 4'd0) begin miscompares++; $display("FAIL logout: got sa %b acc %0d pin %0d want 0/0/0", session_active, acc_number, pin); end
  endtask

  task automatic test_acc_entry;
    press(5); press(0); press(0);
    vectors++; if (acc_number !== 12'd500) begin miscompares++; $display("FAIL acc_partial: got %0d want 500", acc_number); end
    press(0);
    vectors++; if (entry_error !== 1'b1 || digit_count !== 3'd0 || acc_number !== 12'd0) begin miscompares++; $display("FAIL acc_overflow: got err %b dc %0d acc %0d want 1/0/0", entry_error, digit_count, acc_number); end
    @(negedge clk);
    vectors++; if (entry_error !== 1'b0) begin miscompares++; $display("FAIL acc_overflow_pulse: got %b want 0", entry_error); end
    press(1); press(2); press(3); press(4); press(5);
    vectors++; if (acc_number !== 12'd1234 || digit_count !== 3'd4) begin miscompares++; $display("FAIL acc_fifth_digit: got %0d/%0d want 1234/4", acc_number, digit_count); end
    @(negedge clk); logout = 1'b1;
    @(negedge clk); logout = 1'b0;
    vectors++; if (acc_number !== 12'd1234) begin miscompares++; $display("FAIL logout_outside_session: got %0d want 1234", acc_number); end
    press(K_CLR);
    vectors++; if (acc_number !== 12'd0 || digit_count !== 3'd0) begin miscompares++; $display("FAIL acc_clear: got %0d/%0d want 0/0", acc_number, digit_count); end
    press(K_ENT); press(1);
    vectors++; if (acc_number !== 12'd1 || pin !== 4'd0) begin miscompares++; $display("FAIL enter_empty_ignored: got acc %0d pin %0d want 1/0", acc_number, pin); end
    press(K_CAN);
    vectors++; if (acc_number !== 12'd0 || digit_count !== 3'd0) begin miscompares++; $display("FAIL acc_cancel: got %0d/%0d want 0/0", acc_number, digit_count); end
  endtask

  task automatic test_pin_entry;
    press(7); press(K_ENT); press(1); press(7);
    vectors++; if (entry_error !== 1'b1 || pin !== 4'd0 || digit_count !== 3'd0 || acc_number !== 12'd7) begin miscompares++; $display("FAIL pin_overflow: got err %b pin %0d dc %0d acc %0d want 1/0/0/7", entry_error, pin, digit_count, acc_number); end
    press(1); press(5); press(K_ENT);
    vectors++; if (cred_valid !== 1'b1 || pin !== 4'd15) begin miscompares++; $display("FAIL pin_max: got cv %b pin %0d want 1/15", cred_valid, pin); end
    auth(1'b1);
    @(negedge clk); logout = 1'b1;
    @(negedge clk); logout = 1'b0;
  endtask

  task automatic test_idle_timeout;
    press(1);
    repeat (99) @(negedge clk);
    vectors++; if (entry_error !== 1'b0 || digit_count !== 3'd1) begin miscompares++; $display("FAIL idle_early: got err %b dc %0d want 0/1", entry_error, digit_count); end
    @(negedge clk);
    vectors++; if (entry_error !== 1'b1 || digit_count !== 3'd0 || acc_number !== 12'd0 || tries_left !== 2'd3) begin miscompares++; $display("FAIL idle_expire: got err %b dc %0d acc %0d tries %0d want 1/0/0/3", entry_error, digit_count, acc_number, tries_left); end
  endtask

  task automatic test_auth_timeout;
    press(4); press(K_ENT); press(2); press(K_ENT);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      key_valid = (i < 3);
      key_code  = 4'd7;
    end
    vectors++; if (entry_error !== 1'b0 || tries_left !== 2'd3 || pin !== 4'd2 || acc_number !== 12'd4) begin miscompares++; $display("FAIL auth_wait: got err %b tries %0d pin %0d acc %0d want 0/3/2/4", entry_error, tries_left, pin, acc_number); end
    @(negedge clk);
    vectors++; if (entry_error !== 1'b1 || tries_left !== 2'd2 || acc_number !== 12'd0) begin miscompares++; $display("FAIL auth_timeout: got err %b tries %0d acc %0d want 1/2/0", entry_error, tries_left, acc_number); end
    attempt(4'd1, 4'd2, 1'b1);
    vectors++; if (session_active !== 1'b1 || tries_left !== 2'd3) begin miscompares++; $display("FAIL tries_restore: got sa %b tries %0d want 1/3", session_active, tries_left); end
    @(negedge clk); logout = 1'b1;
    @(negedge clk); logout = 1'b0;
  endtask

  task automatic test_lockout;
    for (int a = 0; a < 3; a++) begin
      attempt(4'd1, 4'd1, 1'b0);
      vectors++; if (tries_left !== 2'(2 - a) || entry_error !== 1'b1 || locked !== (a == 2)) begin miscompares++; $display("FAIL lock_attempt%0d: got tries %0d err %b lk %b want %0d/1/%b", a, tries_left, entry_error, locked, 2 - a, a == 2); end
    end
    for (int i = 0; i < 199; i++) begin
      @(negedge clk);
      key_valid = (i < 10);
      key_code  = 4'd9;
    end
    vectors++; if (locked !== 1'b1 || digit_count !== 3'd0 || acc_number !== 12'd0) begin miscompares++; $display("FAIL lock_hold: got lk %b dc %0d acc %0d want 1/0/0", locked, digit_count, acc_number); end
    @(negedge clk);
    vectors++; if (locked !== 1'b0 || tries_left !== 2'd3) begin miscompares++; $display("FAIL lock_release: got lk %b tries %0d want 0/3", locked, tries_left); end
  endtask

  task automatic test_reset_midway;
    press(3); press(K_ENT); press(6); press(K_ENT);
    #1 rst = 1'b1;
    #1;
    vectors++; if (cred_valid !== 1'b0 || acc_number !== 12'd0 || pin !== 4'd0) begin miscompares++; $display("FAIL reset_wait_auth: got cv %b acc %0d pin %0d want 0/0/0", cred_valid, acc_number, pin); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (cred_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_cred%0d: got %b want 0", i, cred_valid); end
    end
    for (int a = 0; a < 3; a++) attempt(4'd2, 4'd2, 1'b0);
    repeat (50) @(negedge clk);
    vectors++; if (locked !== 1'b1 || tries_left !== 2'd0) begin miscompares++; $display("FAIL relock: got lk %b tries %0d want 1/0", locked, tries_left); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (locked !== 1'b0 || tries_left !== 2'd3 || entry_error !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got lk %b tries %0d err %b want 0/3/0", locked, tries_left, entry_error); end
    @(negedge clk); rst = 1'b0;
    press(8);
    vectors++; if (acc_number !== 12'd8) begin miscompares++; $display("FAIL post_reset_entry: got %0d want 8", acc_number); end
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    auth_done = 1'b0;
    auth_ok   = 1'b0;
    logout    = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_login;
    test_acc_entry;
    test_pin_entry;
    test_idle_timeout;
    test_auth_timeout;
    test_lockout;
    test_reset_midway;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/atm_credential_entry.md
Name: atm_credential_entry

Overview:
- Keypad front end that sits directly upstream of the ATM controller and its authentication lookup.
- Collects decimal key presses and assembles a 12-bit account number and a 4-bit PIN.
- Presents the pair to the ATM with a one-cycle strobe, then waits for the auth result.
- Enforces a retry limit with timed lockout and an inactivity timeout during entry.

Parameters:
- MAX_TRIES, 3: consecutive failed authentications before lockout.
- LOCK_CYCLES, 200: clk cycles spent in LOCKED.
- IDLE_TIMEOUT, 100: clk cycles without a key in an entry state before abandoning entry.
- AUTH_TIMEOUT, 16: clk cycles allowed for auth_done after cred_valid.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC CANCEL, 4'hD-F ignored.
- auth_done  in  1  one-cycle strobe from authentication; auth_ok is valid this cycle.
- auth_ok  in  1  1 = account/PIN matched.
- logout  in  1  level or pulse from ATM; ends the session.
- acc_number  out  12  assembled account number; held while cred_valid or session_active.
- pin  out  4  assembled PIN.
- cred_valid  out  1  one-cycle strobe when acc_number/pin are ready for lookup.
- session_active  out  1  high while the user is authenticated.
- locked  out  1  high in LOCKED.
- entry_error  out  1  one-cycle strobe on overflow, timeout, or auth failure.
- digit_count  out  3  digits entered in the current field (0-4).
- tries_left  out  2  remaining attempts.

Behaviour:
- Reset (async, any state) forces:
  - state=ENTER_ACC, acc_number=0, pin=0, all counters=0, tries_left=MAX_TRIES.
  - All strobes and flags low.
- States: ENTER_ACC, ENTER_PIN, WAIT_AUTH, SESSION, LOCKED. Outputs are registered.
- ENTER_ACC:
  - Digit d when digit_count<4: acc_accum = acc_accum*10 + d, computed in 14 bits.
  - If the result is >4095: discard it, clear the field, pulse entry_error.
  - A 5th digit is ignored.
  - ENTER with digit_count≥1 -> ENTER_PIN; ENTER with no digits is ignored.
  - CLEAR zeroes the field.
  - CANCEL clears all fields and stays in ENTER_ACC.
- ENTER_PIN:
  - Same rules as ENTER_ACC, but max 2 digits and the value must be ≤15. 16..99 -> clear field, pulse entry_error.
  - ENTER with ≥1 digit: drive acc_number/pin, pulse cred_valid next cycle, go to WAIT_AUTH.
  - CANCEL -> ENTER_ACC with fields cleared.
- Inactivity: each key press in ENTER_ACC/ENTER_PIN reloads an idle counter. At IDLE_TIMEOUT with no key -> clear fields, pulse entry_error, go to ENTER_ACC. tries_left is unchanged.
- WAIT_AUTH:
  - Keys are ignored.
  - auth_done with auth_ok=1 -> SESSION, session_active=1, tries_left=MAX_TRIES.
  - auth_done with auth_ok=0, or AUTH_TIMEOUT expiry, is a failure:
    - pulse entry_error, decrement tries_left.
    - If tries_left reaches 0 -> LOCKED; else -> ENTER_ACC with fields cleared.
- SESSION:
  - Keys are ignored; acc_number and pin are held.
  - logout=1 -> ENTER_ACC, session_active=0, fields cleared, the same cycle it is sampled.
- LOCKED:
  - locked=1; all keys are ignored.
  - After LOCK_CYCLES cycles -> ENTER_ACC, tries_left=MAX_TRIES.
- Simultaneous events:
  - auth_done and AUTH_TIMEOUT expiry in the same cycle: auth_done wins.
  - key_valid in the same cycle as idle-timeout expiry: the key wins and the counter reloads.
  - logout outside SESSION is ignored.
- digit_count resets to 0 on every field change.

Test Plan:
- Keys 4,0,2,3,ENTER,3,ENTER; then auth_done=1/auth_ok=1 -> one cred_valid pulse with acc_number=4023 and pin=3; session_active=1; tries_left=3.
- Keys 5,0,0,0 -> entry_error pulse, digit_count=0, acc_number field 0, state ENTER_ACC.
- Three attempts each answered auth_ok=0 -> tries_left goes 2,1,0; locked=1 for 200 cycles; keys ignored meanwhile; then ENTER_ACC with tries_left=3.
- PIN keys 1,7 -> entry_error, PIN field cleared. Then 1,5,ENTER -> pin=15.
- One digit, then 100 idle cycles -> entry_error, fields cleared. Also: cred_valid with no auth_done for 16 cycles -> failure, tries_left=2.
- Reset asserted mid-WAIT_AUTH and mid-LOCKED -> immediate return to the reset values, with no cred_valid pulse.
